// File: rtl/uart_pkg.sv
// Definitions shared by the SoC UART transmit and receive paths.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int unsigned UART_DEFAULT_DIV = 434;  // 50 MHz / 115200
  localparam logic [31:0] UART_EMPTY_READ  = 32'hFFFF_FFFF;

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Generic single-clock FIFO. Pointers carry one extra wrap bit so full and
// empty are distinguishable. Head is presented combinationally.
module uart_rx_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // A pop frees the slot the concurrent push writes, so full does not block it.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver with programmable clocks-per-bit divider, receive FIFO
// and sticky framing/overrun flags, exposed as a data/divider register pair.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEFAULT_DIV = UART_DEFAULT_DIV,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ser_rx,
  input  logic        reg_div_we,
  input  logic [31:0] reg_div_di,
  output logic [31:0] reg_div_do,
  input  logic        reg_dat_re,
  output logic [31:0] reg_dat_do,
  output logic        rx_valid,
  input  logic        err_clr,
  output logic        frame_err,
  output logic        overrun_err
);

  rx_state_e   state, state_n;
  logic [31:0] divider;
  logic [31:0] eff_div;
  logic [31:0] half_tick;
  logic [31:0] cnt, cnt_n;
  logic [2:0]  bit_idx, bit_n;
  logic [7:0]  shreg, shreg_n;
  logic        rx_meta, rx_s, rx_d;
  logic        push, frame_set, overrun_set;
  logic        fifo_full, fifo_empty;
  logic [7:0]  fifo_head;

  assign eff_div    = (divider < 32'd2) ? 32'd2 : divider;
  assign half_tick  = (eff_div >> 1) - 32'd1;
  assign reg_div_do = divider;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= ser_rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  // NOTE: every output of this block is defaulted first so no path infers a latch.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bit_n       = bit_idx;
    shreg_n     = shreg;
    push        = 1'b0;
    frame_set   = 1'b0;
    overrun_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_d && !rx_s) begin
          cnt_n   = '0;
          state_n = START;
        end
      end
      START: begin
        if (cnt == half_tick) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      DATA: begin
        if (cnt == eff_div - 32'd1) begin
          cnt_n   = '0;
          shreg_n = {rx_s, shreg[7:1]};
          bit_n   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      STOP: begin
        if (cnt == eff_div - 32'd1) begin
          state_n     = IDLE;
          push        = rx_s;
          frame_set   = !rx_s;
          overrun_set = rx_s && fifo_full && !reg_dat_re;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      default: state_n = IDLE;
    endcase
    // A divider write abandons the current frame silently.
    if (reg_div_we) begin
      state_n     = IDLE;
      push        = 1'b0;
      frame_set   = 1'b0;
      overrun_set = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      divider     <= DEFAULT_DIV;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shreg   <= shreg_n;
      if (reg_div_we) divider <= reg_div_di;
      if (frame_set)        frame_err <= 1'b1;
      else if (err_clr)     frame_err <= 1'b0;
      if (overrun_set)      overrun_err <= 1'b1;
      else if (err_clr)     overrun_err <= 1'b0;
    end
  end

  uart_rx_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .din    (shreg),
    .pop    (reg_dat_re),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (fifo_head)
  );

  assign rx_valid   = !fifo_empty;
  assign reg_dat_do = fifo_empty ? UART_EMPTY_READ : {24'h0, fifo_head};

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: frames are bit-banged on ser_rx and the
// register interface is compared against hand-computed values.
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ser_rx;
  logic        reg_div_we;
  logic [31:0] reg_div_di;
  logic [31:0] reg_div_do;
  logic        reg_dat_re;
  logic [31:0] reg_dat_do;
  logic        rx_valid;
  logic        err_clr;
  logic        frame_err;
  logic        overrun_err;

  int checks   = 0;
  int failures = 0;

  logic        v_before, v_after;
  logic [31:0] popped;

  uart_rx_fifo dut (
    .clk         (clk),
    .resetn      (resetn),
    .ser_rx      (ser_rx),
    .reg_div_we  (reg_div_we),
    .reg_div_di  (reg_div_di),
    .reg_div_do  (reg_div_do),
    .reg_dat_re  (reg_dat_re),
    .reg_dat_do  (reg_dat_do),
    .rx_valid    (rx_valid),
    .err_clr     (err_clr),
    .frame_err   (frame_err),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_div(input logic [31:0] d);
    reg_div_di = d;
    reg_div_we = 1'b1;
    cycles(1);
    reg_div_we = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    cycles(1);
    err_clr = 1'b0;
  endtask

  // Returns the value presented during a one-cycle read strobe.
  task automatic read_pop(output logic [31:0] v);
    reg_dat_re = 1'b1;
    v = reg_dat_do;
    cycles(1);
    reg_dat_re = 1'b0;
  endtask

  // Drives one 8N1 frame; records rx_valid in the STOP-sample cycle and the
  // cycle after, optionally strobing a read exactly in the STOP-sample cycle.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit,
                           input int div, input logic pop_at_stop);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      ser_rx = frame[i];
      for (int j = 1; j <= div; j++) begin
        @(posedge clk);
        #1;
        if (i == 9 && j == 2 + div / 2) begin
          v_before = rx_valid;
          popped   = reg_dat_do;
          if (pop_at_stop) reg_dat_re = 1'b1;
        end
        if (i == 9 && j == 3 + div / 2) begin
          v_after    = rx_valid;
          reg_dat_re = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; ser_rx = 1'b1; reg_div_we = 1'b0; reg_div_di = '0;
    reg_dat_re = 1'b0; err_clr = 1'b0;
    cycles(3);
    checks++; if (reg_div_do !== 32'd434) begin failures++; $display("FAIL reset_div got=%0d exp=434", reg_div_do); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
    checks++; if (reg_dat_do !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_dat got=%h exp=ffffffff", reg_dat_do); end
    checks++; if ({frame_err, overrun_err} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {frame_err, overrun_err}); end
    resetn = 1'b1;
    cycles(2);
  endtask

  task automatic test_basic();
    logic [31:0] v;
    write_div(32'd8);
    checks++; if (reg_div_do !== 32'd8) begin failures++; $display("FAIL div_write got=%0d exp=8", reg_div_do); end
    send_byte(8'hA5, 1'b1, 8, 1'b0);
    checks++; if ({v_before, v_after} !== 2'b01) begin failures++; $display("FAIL basic_latency got=%b exp=01", {v_before, v_after}); end
    checks++; if (reg_dat_do !== 32'h0000_00A5) begin failures++; $display("FAIL basic_data got=%h exp=000000a5", reg_dat_do); end
    read_pop(v);
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_after_read got=%b exp=0", rx_valid); end
    checks++; if (reg_dat_do !== 32'hFFFF_FFFF) begin failures++; $display("FAIL basic_empty_read got=%h exp=ffffffff", reg_dat_do); end
  endtask

  task automatic test_overrun();
    logic [31:0] v;
    for (int k = 1; k <= 5; k++) send_byte(8'(k), 1'b1, 8, 1'b0);
    cycles(2);
    checks++; if (overrun_err !== 1'b1) begin failures++; $display("FAIL overrun_set got=%b exp=1", overrun_err); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL overrun_no_frame got=%b exp=0", frame_err); end
    for (int k = 1; k <= 4; k++) begin
      read_pop(v);
      checks++; if (v !== 32'(k)) begin failures++; $display("FAIL overrun_read%0d got=%h exp=%h", k, v, 32'(k)); end
    end
    read_pop(v);
    checks++; if (v !== 32'hFFFF_FFFF) begin failures++; $display("FAIL overrun_read5 got=%h exp=ffffffff", v); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL overrun_empty_valid got=%b exp=0", rx_valid); end
    pulse_clr();
    checks++; if (overrun_err !== 1'b0) begin failures++; $display("FAIL overrun_clear got=%b exp=0", overrun_err); end
  endtask

  task automatic test_frame_error();
    send_byte(8'h3C, 1'b0, 8, 1'b0);
    ser_rx = 1'b1;
    cycles(4);
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL frame_set got=%b exp=1", frame_err); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL frame_no_push got=%b exp=0", rx_valid); end
    pulse_clr();
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL frame_clear got=%b exp=0", frame_err); end
  endtask

  task automatic test_glitch();
    cycles(10);
    ser_rx = 1'b0;
    cycles(2);
    ser_rx = 1'b1;
    cycles(120);
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL glitch_push got=%b exp=0", rx_valid); end
    checks++; if ({frame_err, overrun_err} !== 2'b00) begin failures++; $display("FAIL glitch_flags got=%b exp=00", {frame_err, overrun_err}); end
  endtask

  task automatic test_pop_push_full();
    logic [31:0] v;
    logic [7:0]  exp_b [4];
    exp_b = '{8'h22, 8'h33, 8'h44, 8'h55};
    send_byte(8'h11, 1'b1, 8, 1'b0);
    send_byte(8'h22, 1'b1, 8, 1'b0);
    send_byte(8'h33, 1'b1, 8, 1'b0);
    send_byte(8'h44, 1'b1, 8, 1'b0);
    send_byte(8'h55, 1'b1, 8, 1'b1);
    cycles(2);
    checks++; if (popped !== 32'h11) begin failures++; $display("FAIL popush_popped got=%h exp=00000011", popped); end
    checks++; if (overrun_err !== 1'b0) begin failures++; $display("FAIL popush_overrun got=%b exp=0", overrun_err); end
    for (int k = 0; k < 4; k++) begin
      read_pop(v);
      checks++; if (v !== {24'h0, exp_b[k]}) begin failures++; $display("FAIL popush_read%0d got=%h exp=%h", k, v, exp_b[k]); end
    end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL popush_drained got=%b exp=0", rx_valid); end
  endtask

  task automatic test_abort();
    logic [31:0] v;
    ser_rx = 1'b0;
    cycles(8);
    ser_rx = 1'b1;
    cycles(4);
    write_div(32'd16);
    cycles(200);
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL abort_push got=%b exp=0", rx_valid); end
    checks++; if ({frame_err, overrun_err} !== 2'b00) begin failures++; $display("FAIL abort_flags got=%b exp=00", {frame_err, overrun_err}); end
    checks++; if (reg_div_do !== 32'd16) begin failures++; $display("FAIL abort_div got=%0d exp=16", reg_div_do); end
    send_byte(8'h96, 1'b1, 16, 1'b0);
    checks++; if ({v_before, v_after} !== 2'b01) begin failures++; $display("FAIL div16_latency got=%b exp=01", {v_before, v_after}); end
    read_pop(v);
    checks++; if (v !== 32'h96) begin failures++; $display("FAIL div16_data got=%h exp=00000096", v); end
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'h3C, 1'b0, 16, 1'b0);
    ser_rx = 1'b1;
    cycles(4);
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL premid_frame got=%b exp=1", frame_err); end
    send_byte(8'h5A, 1'b1, 16, 1'b0);
    ser_rx = 1'b0;
    cycles(40);
    #2 resetn = 1'b0;
    #1;
    checks++; if (reg_div_do !== 32'd434) begin failures++; $display("FAIL midreset_div got=%0d exp=434", reg_div_do); end
    checks++; if ({frame_err, overrun_err} !== 2'b00) begin failures++; $display("FAIL midreset_flags got=%b exp=00", {frame_err, overrun_err}); end
    checks++; if (rx_valid !== 1'b0 || reg_dat_do !== 32'hFFFF_FFFF) begin failures++; $display("FAIL midreset_fifo got=%b/%h exp=0/ffffffff", rx_valid, reg_dat_do); end
    ser_rx = 1'b1;
    cycles(3);
    resetn = 1'b1;
    cycles(100);
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL midreset_discard got=%b exp=0", rx_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_frame_error();
    test_glitch();
    test_pop_push_full();
    test_abort();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Serial receiver for the SoC's `ser_rx` line. It is the receive-side counterpart of the SoC UART transmitter, with the same 8N1 framing and the same programmable clock divider. Received bytes go into a small FIFO. The CPU reads that FIFO through a simple memory-mapped data/divider register pair. The block sits inside `riscv_i`, next to the TX path, on the `ser_rx` pin.

Parameters:
- DEFAULT_DIV, 434, reset value of the divider in clocks per bit (50 MHz / 115200).
- FIFO_DEPTH, 4, number of receive FIFO entries; must be a power of 2, minimum 2.

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- ser_rx  input  1  asynchronous serial input; idles high
- reg_div_we  input  1  one-cycle strobe that writes the divider
- reg_div_di  input  32  new divider value
- reg_div_do  output  32  current divider value
- reg_dat_re  input  1  one-cycle read strobe; pops the FIFO
- reg_dat_do  output  32  {24'h0, head byte} when data is available; 32'hFFFF_FFFF when the FIFO is empty
- rx_valid  output  1  FIFO not empty
- err_clr  input  1  clears the sticky error flags
- frame_err  output  1  sticky flag: a stop bit was sampled low
- overrun_err  output  1  sticky flag: a byte was dropped because the FIFO was full

Behaviour:
- Reset values:
  - divider = DEFAULT_DIV
  - FIFO empty; rx_valid = 0; reg_dat_do = 32'hFFFF_FFFF
  - frame_err = 0; overrun_err = 0
  - FSM in IDLE; synchronizer flops = 1
- Input synchronizer: `ser_rx` passes through 2 flops giving `rx_s`, plus one more flop giving `rx_d` for edge detection. Latency from pin to FSM is 2 cycles.
- Effective divider: eff_div = max(divider, 2). The bit counter is 32 bits wide and counts 0..eff_div-1.
- FSM states and transitions:
  - IDLE: on `rx_d`=1 and `rx_s`=0 (falling edge), clear the counter and go to START. A line held low never retriggers.
  - START: when counter = eff_div/2 - 1 (floor), sample `rx_s`.
    - Sample 0: clear counter and bit index; go to DATA.
    - Sample 1: glitch; go to IDLE.
  - DATA: every eff_div cycles, shift `rx_s` into the shift register, LSB first. After bit 7, go to STOP.
  - STOP: after eff_div cycles, sample `rx_s`.
    - 1 and FIFO not full: push the byte.
    - 1 and FIFO full, with no pop in the same cycle: drop the byte and set overrun_err.
    - 0: set frame_err and do not push.
    - In all cases return to IDLE.
- Sampling point: every bit is sampled at its mid-point, ±1 cycle.
- FIFO:
  - Circular buffer with read and write pointers one bit wider than log2(FIFO_DEPTH); pointers wrap modulo 2*FIFO_DEPTH.
  - Push-to-visible latency is 1 cycle: rx_valid rises the cycle after the STOP sample.
  - `reg_dat_do` is combinational from the head entry.
  - `reg_dat_re` while empty: no pointer change; the read returns all-ones.
  - Pop and push in the same cycle while full: both take effect, count is unchanged, no overrun.
- Divider write:
  - `reg_div_we` updates the divider on the next edge.
  - It also forces the FSM to IDLE and aborts any in-flight frame without setting any flag.
  - FIFO contents and error flags are unaffected.
- Error flags:
  - `err_clr` clears both flags.
  - If `err_clr` and a new error event occur in the same cycle, the set wins.
- Reset mid-frame: everything returns immediately to reset values; a partially received byte is discarded.

Decomposition:
- Shared package `uart_pkg`:
  - FSM state enumeration: IDLE, START, DATA, STOP
  - UART_DEFAULT_DIV constant, also used by the TX block
  - empty-read value 32'hFFFF_FFFF
- One natural sub-module, `uart_rx_sync_fifo`: a generic synchronous FIFO with parameters WIDTH=8 and DEPTH, and ports push, pop, full, empty, head.

Test Plan:
- Basic receive: divider = 8; drive byte 8'hA5 as 8N1 at 8 clocks per bit → rx_valid = 1 one cycle after the stop sample; reg_dat_do = 32'h0000_00A5; after a reg_dat_re pulse, rx_valid = 0 and reg_dat_do = 32'hFFFF_FFFF.
- FIFO full and overrun: send 8'h01..8'h05 back-to-back with no reads → overrun_err = 1; four reads return 8'h01, 8'h02, 8'h03, 8'h04; the fifth read returns all-ones.
- Framing error: send 8'h3C with the stop bit driven low → frame_err = 1, rx_valid stays 0; err_clr → frame_err = 0.
- Glitch rejection: pulse ser_rx low for 2 cycles with divider = 8 → FSM returns to IDLE, no push, no error flag.
- Simultaneous pop and push when full: fill the FIFO, then assert reg_dat_re in the exact cycle of the next STOP sample → overrun_err stays 0 and the FIFO stays full with the new byte at the tail.
- Abort and reset: assert reg_div_we mid-DATA → no push and no flag, and a following frame at the new divider is received correctly; assert resetn = 0 mid-frame → reg_div_do = 434 and all flags = 0.
